// File: rtl/pipeline_fetch_ifid_if.sv
// Instruction memory bus between the fetch stage and imem.
// master = fetch side, slave = memory side.
interface pipeline_fetch_ifid_if;
    logic        ihit;
    logic [31:0] imemload;
    logic        imemREN;
    logic [31:0] imemaddr;

    modport master (
        input  ihit,
        input  imemload,
        output imemREN,
        output imemaddr
    );

    modport slave (
        output ihit,
        output imemload,
        input  imemREN,
        input  imemaddr
    );
endinterface

// File: rtl/pipeline_fetch_ifid.sv
// Fetch stage + IF/ID latch with skid buffer and HALT state.
// Optional IFID_PERF_EN adds fetch_cnt / bubble_cnt outputs.
module pipeline_fetch_ifid #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter logic [5:0]  HALT_OP = 6'b111111
) (
    input  logic                 CLK,
    input  logic                 nRST,
    pipeline_fetch_ifid_if.master imem,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 redir_en,
    input  logic [31:0]          redir_pc,
    output logic [31:0]          instr_l,
    output logic [31:0]          pc_l,
    output logic [31:0]          npc_l,
    output logic                 valid_l,
    output logic                 fetch_halted
`ifdef IFID_PERF_EN
    ,
    output logic [31:0]          fetch_cnt,
    output logic [31:0]          bubble_cnt
`endif
);

    typedef enum logic [1:0] {RUN, HOLD, HALT} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_inc;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;
    logic        fetch_is_halt;
    logic        skid_is_halt;

    logic        ld_bub;
    logic        ld_val;
    logic [31:0] ld_instr;
    logic [31:0] ld_pc;

    assign pc_inc        = pc + 32'd4;
    assign fetch_is_halt = (imem.imemload[31:26] == HALT_OP);
    assign skid_is_halt  = (skid_instr[31:26] == HALT_OP);

    assign imem.imemaddr = pc;
    assign imem.imemREN  = (state == RUN);
    assign fetch_halted  = (state == HALT);

    // Decide what the IF/ID latch loads this cycle: bubble, new word or hold.
    always_comb begin
        ld_bub   = 1'b0;
        ld_val   = 1'b0;
        ld_instr = imem.imemload;
        ld_pc    = pc;
        if (redir_en || flush) begin
            ld_bub = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (!stall) begin
                        if (imem.ihit) ld_val = 1'b1;
                        else           ld_bub = 1'b1;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        ld_val   = 1'b1;
                        ld_instr = skid_instr;
                        ld_pc    = skid_pc;
                    end
                end
                HALT: begin
                    if (!stall) ld_bub = 1'b1;
                end
                default: begin
                    ld_bub = 1'b1;
                end
            endcase
        end
    end

    // PC, skid buffer and RUN/HOLD/HALT state machine.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= RUN;
            pc         <= PC_INIT;
            skid_instr <= '0;
            skid_pc    <= '0;
        end else if (redir_en) begin
            state      <= RUN;
            pc         <= redir_pc;
            skid_instr <= '0;
            skid_pc    <= '0;
        end else if (flush) begin
            skid_instr <= '0;
            skid_pc    <= '0;
            if (state == HOLD) state <= RUN;
        end else begin
            case (state)
                RUN: begin
                    if (imem.ihit) begin
                        if (stall) begin
                            skid_instr <= imem.imemload;
                            skid_pc    <= pc;
                            state      <= HOLD;
                        end else if (fetch_is_halt) begin
                            state <= HALT;
                        end
                        if (!fetch_is_halt) pc <= pc_inc;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        state      <= skid_is_halt ? HALT : RUN;
                        skid_instr <= '0;
                        skid_pc    <= '0;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    // IF/ID pipeline latch.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            instr_l <= '0;
            pc_l    <= '0;
            npc_l   <= '0;
            valid_l <= 1'b0;
        end else if (ld_bub) begin
            instr_l <= '0;
            pc_l    <= '0;
            npc_l   <= '0;
            valid_l <= 1'b0;
        end else if (ld_val) begin
            instr_l <= ld_instr;
            pc_l    <= ld_pc;
            npc_l   <= ld_pc + 32'd4;
            valid_l <= 1'b1;
        end
    end

`ifdef IFID_PERF_EN
    // Count valid loads and bubble loads into IF/ID.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fetch_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (ld_val) fetch_cnt  <= fetch_cnt + 32'd1;
            if (ld_bub) bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_fetch_ifid.sv
// Scoreboard bench for pipeline_fetch_ifid: directed vectors push
// expected post-edge state, a monitor pops and compares after each edge.
module tb_pipeline_fetch_ifid;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redir_en = 1'b0;
    logic [31:0] redir_pc = '0;
    logic [31:0] instr_l;
    logic [31:0] pc_l;
    logic [31:0] npc_l;
    logic        valid_l;
    logic        fetch_halted;
`ifdef IFID_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] bubble_cnt;
    logic [31:0] b0;
`endif

    pipeline_fetch_ifid_if imem();

    pipeline_fetch_ifid dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .imem        (imem),
        .stall       (stall),
        .flush       (flush),
        .redir_en    (redir_en),
        .redir_pc    (redir_pc),
        .instr_l     (instr_l),
        .pc_l        (pc_l),
        .npc_l       (npc_l),
        .valid_l     (valid_l),
        .fetch_halted(fetch_halted)
`ifdef IFID_PERF_EN
        ,
        .fetch_cnt   (fetch_cnt),
        .bubble_cnt  (bubble_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          id;
        logic [31:0] instr;
        logic [31:0] pcl;
        logic [31:0] npcl;
        logic [31:0] addr;
        logic        vl;
        logic        ren;
        logic        h;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   sid = 0;

    task automatic chk(input string nm, input int id,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%h want=%h", nm, id, act, exp);
        end
    endtask

    task automatic chk_all(input exp_t e);
        chk("instr_l", e.id, instr_l, e.instr);
        chk("pc_l", e.id, pc_l, e.pcl);
        chk("npc_l", e.id, npc_l, e.npcl);
        chk("valid_l", e.id, {31'b0, valid_l}, {31'b0, e.vl});
        chk("imemaddr", e.id, imem.imemaddr, e.addr);
        chk("imemREN", e.id, {31'b0, imem.imemREN}, {31'b0, e.ren});
        chk("fetch_halted", e.id, {31'b0, fetch_halted}, {31'b0, e.h});
    endtask

    // Drive one cycle of inputs and queue the expected post-edge state.
    task automatic step(input int ih, input logic [31:0] ld,
                        input int st, input int fl, input int rd,
                        input logic [31:0] rpc,
                        input logic [31:0] ei, input logic [31:0] ep,
                        input logic [31:0] en, input int ev,
                        input logic [31:0] ea, input int er, input int eh);
        exp_t e;
        @(negedge CLK);
        imem.ihit     = (ih != 0);
        imem.imemload = ld;
        stall         = (st != 0);
        flush         = (fl != 0);
        redir_en      = (rd != 0);
        redir_pc      = rpc;
        sid++;
        e.id    = sid;
        e.instr = ei;
        e.pcl   = ep;
        e.npcl  = en;
        e.vl    = (ev != 0);
        e.addr  = ea;
        e.ren   = (er != 0);
        e.h     = (eh != 0);
        sb.push_back(e);
    endtask

    initial begin : mon
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk_all(e);
            end
        end
    end

    initial begin : stim
        exp_t r;
        imem.ihit     = 1'b0;
        imem.imemload = '0;
        #2;
        r = '{0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0};
        chk_all(r);
        @(negedge CLK);
        nRST = 1'b1;

        step(1, 32'h2001_0005, 0, 0, 0, 0, 32'h2001_0005, 32'h0, 32'h4, 1, 32'h4, 1, 0);
        step(1, 32'h2002_0007, 0, 0, 0, 0, 32'h2002_0007, 32'h4, 32'h8, 1, 32'h8, 1, 0);
        step(1, 32'h2003_0009, 1, 0, 0, 0, 32'h2002_0007, 32'h4, 32'h8, 1, 32'hC, 0, 0);
        step(0, 32'h0, 1, 0, 0, 0, 32'h2002_0007, 32'h4, 32'h8, 1, 32'hC, 0, 0);
        step(0, 32'h0, 1, 0, 0, 0, 32'h2002_0007, 32'h4, 32'h8, 1, 32'hC, 0, 0);
        step(0, 32'h0, 0, 0, 0, 0, 32'h2003_0009, 32'h8, 32'hC, 1, 32'hC, 1, 0);
        step(1, 32'h2004_000B, 0, 0, 0, 0, 32'h2004_000B, 32'hC, 32'h10, 1, 32'h10, 1, 0);
        step(1, 32'h2005_0000, 1, 0, 1, 32'h40, 0, 0, 0, 0, 32'h40, 1, 0);
        step(0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h40, 1, 0);
        step(1, 32'h2006_0001, 0, 0, 0, 0, 32'h2006_0001, 32'h40, 32'h44, 1, 32'h44, 1, 0);
        step(0, 32'h0, 0, 0, 1, 32'h10, 0, 0, 0, 0, 32'h10, 1, 0);
        step(1, 32'hFC00_0000, 0, 0, 0, 0, 32'hFC00_0000, 32'h10, 32'h14, 1, 32'h10, 0, 1);
        step(1, 32'h2007_0000, 1, 0, 0, 0, 32'hFC00_0000, 32'h10, 32'h14, 1, 32'h10, 0, 1);
        step(1, 32'h2007_0000, 0, 0, 0, 0, 0, 0, 0, 0, 32'h10, 0, 1);
        step(0, 32'h0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h10, 0, 1);
        step(0, 32'h0, 0, 0, 1, 32'h20, 0, 0, 0, 0, 32'h20, 1, 0);
`ifdef IFID_PERF_EN
        @(posedge CLK);
        #2;
        b0 = bubble_cnt;
`endif
        step(0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h20, 1, 0);
        step(0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h20, 1, 0);
`ifdef IFID_PERF_EN
        @(posedge CLK);
        #2;
        chk("bubble_cnt_delta", sid, bubble_cnt - b0, 32'd2);
`endif
        step(1, 32'h2008_0002, 0, 0, 0, 0, 32'h2008_0002, 32'h20, 32'h24, 1, 32'h24, 1, 0);
        step(0, 32'h0, 1, 0, 0, 0, 32'h2008_0002, 32'h20, 32'h24, 1, 32'h24, 1, 0);
        step(1, 32'h2009_0000, 0, 1, 0, 0, 0, 0, 0, 0, 32'h24, 1, 0);
        step(1, 32'h200A_0000, 1, 0, 0, 0, 0, 0, 0, 0, 32'h28, 0, 0);
        step(0, 32'h0, 1, 1, 0, 0, 0, 0, 0, 0, 32'h28, 1, 0);
        step(1, 32'hFC00_0001, 1, 0, 0, 0, 0, 0, 0, 0, 32'h28, 0, 0);
        step(0, 32'h0, 0, 0, 0, 0, 32'hFC00_0001, 32'h28, 32'h2C, 1, 32'h28, 0, 1);
        step(0, 32'h0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 32'hFFFF_FFFC, 1, 0);
        step(1, 32'h200B_0000, 0, 0, 0, 0, 32'h200B_0000, 32'hFFFF_FFFC, 32'h0, 1, 32'h0, 1, 0);
        step(0, 32'h0, 0, 0, 1, 32'h102, 0, 0, 0, 0, 32'h102, 1, 0);
        step(1, 32'h200C_0000, 0, 0, 0, 0, 32'h200C_0000, 32'h102, 32'h106, 1, 32'h106, 1, 0);
        step(1, 32'h200D_0000, 1, 0, 0, 0, 32'h200C_0000, 32'h102, 32'h106, 1, 32'h10A, 0, 0);

        @(posedge CLK);
        #3;
        nRST = 1'b0;
        #1;
        r = '{99, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0};
        chk_all(r);
        @(negedge CLK);
        imem.ihit = 1'b0;
        stall     = 1'b0;
        nRST      = 1'b1;
        step(1, 32'h200E_0000, 0, 0, 0, 0, 32'h200E_0000, 32'h0, 32'h4, 1, 32'h4, 1, 0);

        @(negedge CLK);
        imem.ihit = 1'b0;
        @(negedge CLK);
        chk("sb_drain", sid, sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_fetch_ifid.md
Name: pipeline_fetch_ifid

Overview:
- Fetch stage plus IF/ID pipeline latch: owns the PC, drives instruction memory requests and latches fetched instructions for decode.
- Sits directly upstream of decode and the ID/EX latch.
- Honours hazard-unit stall, branch/jump redirect and flush.
- A skid buffer holds an instruction that arrives during a stall.
- A halt state stops fetching after a HALT opcode.

Parameters:
- PC_INIT, 32'h0000_0000, PC value after reset.
- HALT_OP, 6'b111111, opcode (instr[31:26]) that stops fetching.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- ihit  in  1  instruction memory returned imemload this cycle.
- imemload  in  32  instruction data.
- imemREN  out  1  instruction read request.
- imemaddr  out  32  fetch address; equals pc.
- stall  in  1  hold the IF/ID latch; from hazard unit.
- flush  in  1  squash the IF/ID contents.
- redir_en  in  1  branch/jump taken, resolved downstream.
- redir_pc  in  32  redirect target.
- instr_l  out  32  latched instruction.
- pc_l  out  32  PC of instr_l.
- npc_l  out  32  pc_l + 4.
- valid_l  out  1  instr_l is a real instruction; 0 means bubble.
- fetch_halted  out  1  HALT fetched; no further requests.

Behaviour:
- Async reset (nRST=0):
  - pc=PC_INIT; instr_l, pc_l, npc_l, valid_l = 0.
  - Skid buffer cleared; state=RUN; fetch_halted=0.
  - Reset mid-fetch discards everything.
- States: RUN, HOLD, HALT.
- Outputs: imemREN = (state==RUN); imemaddr = pc (combinational); fetch_halted = (state==HALT).
- Priority per cycle: redir_en > flush > stall > normal.
- redir_en=1, any state:
  - pc <= redir_pc.
  - IF/ID <= bubble (all zero, valid_l=0).
  - Skid cleared; state <= RUN; an ihit this cycle is discarded.
- flush=1, redir_en=0:
  - IF/ID <= bubble; skid cleared.
  - From HOLD: state <= RUN, pc unchanged (the skid instruction is dropped; pc already points past it).
  - From RUN with ihit: fetched word dropped, pc unchanged.
- RUN, ihit=1, stall=0:
  - instr_l <= imemload; pc_l <= pc; npc_l <= pc+4; valid_l <= 1.
  - If imemload[31:26]==HALT_OP: state <= HALT, pc unchanged. Otherwise pc <= pc+4.
- RUN, ihit=1, stall=1:
  - Skid <= {imemload, pc}; IF/ID unchanged.
  - pc <= pc+4; state <= HOLD.
  - If the captured word is HALT, pc unchanged.
- RUN, ihit=0, stall=0: IF/ID <= bubble; pc unchanged.
- RUN, ihit=0, stall=1: everything holds.
- HOLD, stall=1: holds; imemREN=0.
- HOLD, stall=0: IF/ID <= skid contents with valid_l=1; state <= RUN, or HALT if the skid word is HALT_OP.
- HALT:
  - imemREN=0; IF/ID holds while stall=1, else loads a bubble after the HALT instruction is consumed.
  - Exits only via redir_en or reset. A HALT fetched in a branch shadow is cancelled by the redirect.
- Arithmetic: pc+4 is 32-bit modulo, so 32'hFFFF_FFFC wraps to 0. redir_pc is used unaligned as given.
- Latency: ihit in cycle N, not stalled → instr_l visible cycle N+1.

Optional Feature:
- Macro: IFID_PERF_EN.
- Defined:
  - Adds outputs fetch_cnt (32) and bubble_cnt (32), reset to 0, wrap modulo 2^32.
  - fetch_cnt increments each cycle IF/ID loads valid_l=1.
  - bubble_cnt increments each cycle IF/ID loads a bubble (including flush/redirect).
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, then ihit=1 every cycle, imemload = 0x2001_0005, 0x2002_0007 → imemaddr 0x0, 0x4, 0x8; instr_l/pc_l follow one cycle later, valid_l=1.
- At pc=0x8, ihit=1 with stall=1 for 3 cycles → state HOLD, imemREN=0, pc=0xC, IF/ID unchanged. Stall drops → instr_l = skid word, pc_l=0x8.
- redir_en=1, redir_pc=0x40 in the same cycle as ihit and stall → IF/ID bubble, skid cleared, next imemaddr=0x40.
- Fetch 0xFC00_0000 (HALT) at 0x10 → instr_l=HALT, fetch_halted=1, imemREN=0, pc stays 0x10. Then redir_en to 0x20 → RUN resumes at 0x20.
- ihit=0 for 2 cycles with stall=0 → valid_l=0 twice, pc unchanged. With IFID_PERF_EN: bubble_cnt+=2.
- Assert nRST mid-HOLD asynchronously (no clock edge) → outputs zero and pc=PC_INIT immediately. pc=0xFFFF_FFFC with ihit → next pc=0x0.
